// File: rtl/instr_fetch.sv
// Instruction fetch unit: at most one outstanding memory request feeding a small in-order buffer.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds a sticky fetch_fault output.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  // PCs are held as word addresses so alignment and the 2^32 wrap come for free.
  logic [29:0]       fetch_word_reg, fetch_word_next;
  logic [29:0]       pend_word_reg;
  logic [29:0]       target_word;

  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [31:0]       data_q [BUF_DEPTH];
  logic [31:0]       pc_q   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] wr_en;

  logic              req_fire;
  logic              rsp_push;
  logic              pop;
  logic              halted;

  assign target_word = redirect_target[31:2];

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
      fault_reg <= 1'b1;
    end
  end

  assign fetch_fault = fault_reg;
  assign halted      = fault_reg;
`else
  // Low target bits are deliberately dropped; this keeps them visibly consumed.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];
  assign halted             = 1'b0;
`endif

  // Outstanding is zero whenever the FSM sits in FETCH, so only buffer occupancy gates requests.
  assign imem_req_valid = (state_reg == FETCH) && (count_reg < FULL_CNT) && !halted;
  assign imem_req_addr  = {fetch_word_reg, 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_push       = (state_reg == WAIT) && imem_rsp_valid && !redirect;

  assign instr_valid    = (count_reg != '0);
  assign pop            = instr_valid && instr_ready && !redirect;
  assign instruction    = data_q[head_reg];
  assign instr_pc       = pc_q[head_reg];

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (req_fire) begin
          state_next = redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_next = FETCH;
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_word_next = fetch_word_reg;
    if (redirect) begin
      fetch_word_next = target_word;
    end else if (req_fire) begin
      fetch_word_next = fetch_word_reg + 30'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      fetch_word_reg <= RESET_PC[31:2];
      pend_word_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_word_reg <= fetch_word_next;
      if (req_fire) begin
        pend_word_reg <= fetch_word_reg;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (redirect) begin
      count_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end else begin
      if (rsp_push) begin
        tail_next = tail_reg + PTR_ONE;
      end
      if (pop) begin
        head_next = head_reg + PTR_ONE;
      end
      unique case ({rsp_push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = rsp_push && (tail_reg == PTR_W'(gi));
    end
  endgenerate

  // Entries are cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      count_reg <= count_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_en[i]) begin
          data_q[i] <= imem_rsp_data;
          pc_q[i]   <= {pend_word_reg, 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push expected PCs, monitors compare deliveries.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic [31:0] instruction, instr_pc, redirect_target;
  logic        instr_valid, instr_ready, redirect;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault, fetch_fault2;
`endif

  // second instance for the wrap-around reset PC
  logic        req_valid2, req_ready2, rsp_valid2, instr_valid2;
  logic [31:0] req_addr2, rsp_data2, instruction2, instr_pc2;
  logic        instr_ready2 = 1'b1;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_target2 = 32'h0;

  int grants = 0;
  int grants2 = 0;
  int lat = 1;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q2[$];

  assign imem_req_ready = (grants > 0);
  assign req_ready2     = (grants2 > 0);

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] TGT4 = 32'h0000_0200;
`else
  localparam logic [31:0] TGT4 = 32'h0000_0203;
`endif

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .instruction(instruction2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(instr_ready2),
    .redirect(redirect2), .redirect_target(redirect_target2)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string nm, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_accept(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no request acceptance expected one within 50 cycles", nm);
    end
    step();
  endtask

  // memory model for dut: in-order, programmable latency, aborted by rst
  logic [31:0] m_addr;
  logic        m_abort;
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && !rst) begin
        m_addr = imem_req_addr;
        @(posedge clk);
        #1;
        grants--;
        m_abort = rst;
        repeat (lat - 1) begin
          @(posedge clk);
          #1;
          if (rst) m_abort = 1'b1;
        end
        if (!m_abort && !rst) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(m_addr);
          @(posedge clk);
          #1;
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  // memory model for dut2: fixed 1-cycle latency
  logic        m2_acc;
  logic [31:0] m2_addr;
  initial begin
    rsp_valid2 = 1'b0;
    rsp_data2  = '0;
    forever begin
      @(negedge clk);
      m2_acc  = req_valid2 && req_ready2 && !rst;
      m2_addr = req_addr2;
      @(posedge clk);
      #1;
      if (m2_acc) grants2--;
      rsp_valid2 = m2_acc && !rst;
      rsp_data2  = mem_word(m2_addr);
    end
  end

  // scoreboard monitors
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready && !redirect) begin
        $display("deliver pc=%h data=%h", instr_pc, instruction);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL deliver_unexpected: got pc %h expected no delivery", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", instr_pc, e);
          check("deliver_data", instruction, mem_word(e));
        end
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid2 && instr_ready2) begin
        $display("wrap deliver pc=%h data=%h", instr_pc2, instruction2);
        if (exp_q2.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wrap_unexpected: got pc %h expected no delivery", instr_pc2);
        end else begin
          e = exp_q2.pop_front();
          check("wrap_pc", instr_pc2, e);
          check("wrap_data", instruction2, mem_word(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held_pc, held_data;
    bit found;
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    repeat (3) step();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    rst = 1'b0;
    check("idle_cycle_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    check("wrap_first_addr", req_addr2, 32'hFFFF_FFF8);

    // in-order streaming, and the wrapping instance in parallel
    grants2 = 3;
    exp_q2.push_back(32'hFFFF_FFF8);
    exp_q2.push_back(32'hFFFF_FFFC);
    exp_q2.push_back(32'h0000_0000);
    grants = 3;
    instr_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    drain("stream_drain", 60);
    for (int k = 0; k < 30 && exp_q2.size() != 0; k++) step();
    check("wrap_drain", 32'(exp_q2.size()), 32'd0);
    repeat (2) step();
    check("stream_empty", {31'd0, instr_valid}, 32'd0);
    check("stream_next_addr", imem_req_addr, 32'hC);

    // backpressure: buffer fills to depth and requests stop
    instr_ready = 1'b0;
    grants = 10;
    repeat (12) step();
    check("full_req_count", 32'(grants), 32'd8);
    check("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("full_instr_valid", {31'd0, instr_valid}, 32'd1);
    check("full_head_pc", instr_pc, 32'hC);
    held_pc = instr_pc;
    held_data = instruction;
    repeat (3) step();
    check("stable_pc", instr_pc, held_pc);
    check("stable_data", instruction, held_data);
    grants = 0;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    instr_ready = 1'b1;
    drain("full_drain", 20);
    instr_ready = 1'b0;

    // redirect while a response is in flight, with a buffered word to flush
    grants = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    check("buffered_before_redirect", {31'd0, found}, 32'd1);
    lat = 3;
    grants = 1;
    wait_accept("accept_0x18");
    redirect = 1'b1;
    redirect_target = 32'h100;
    instr_ready = 1'b1;
    grants = 2;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    step();
    redirect = 1'b0;
    check("flush_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("drop_no_req", {31'd0, imem_req_valid}, 32'd0);
    drain("redirect_drain", 60);

    // redirect coincident with the response; target low bits are ignored
    lat = 2;
    grants = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (imem_rsp_valid) found = 1'b1;
    end
    check("rsp_seen", {31'd0, found}, 32'd1);
    redirect = 1'b1;
    redirect_target = TGT4;
    grants = 1;
    step();
    redirect = 1'b0;
    check("coincident_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("coincident_req_addr", imem_req_addr, 32'h200);
    exp_q.push_back(32'h200);
    drain("coincident_drain", 40);

    // reset while waiting on a response
    lat = 3;
    grants = 1;
    wait_accept("accept_0x204");
    rst = 1'b1;
    step();
    check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("midrst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_instruction", instruction, 32'd0);
    check("midrst_instr_pc", instr_pc, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    grants = 2;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    step();
    check("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("restart_addr", imem_req_addr, 32'h0);
    drain("restart_drain", 40);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect = 1'b1;
    redirect_target = 32'h102;
    step();
    redirect = 1'b0;
    check("fault_set", {31'd0, fetch_fault}, 32'd1);
    check("fault_flush", {31'd0, instr_valid}, 32'd0);
    grants = 5;
    repeat (10) step();
    check("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
    check("fault_no_accept", 32'(grants), 32'd5);
`endif

    repeat (4) step();
    check("final_queue", 32'(exp_q.size()), 32'd0);
    check("final_queue2", 32'(exp_q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
